// File: rtl/img_buffer_pkg.sv
// Shared types for the image-buffer frame controller: stream modes, FSM states,
// default-width counter typedefs and the raw mode-field decoder.
package img_buffer_pkg;

  typedef enum logic [1:0] {
    MODE_STOP    = 2'd0,
    MODE_CONT    = 2'd1,
    MODE_ONESHOT = 2'd2
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_PASS  = 2'd2
  } state_e;

  localparam int DEF_BUF_SIZE  = 640 * 480;
  localparam int DEF_SKIP_BITS = 8;
  localparam int DEF_PIX_BITS  = $clog2(DEF_BUF_SIZE) + 1;

  typedef logic [DEF_SKIP_BITS-1:0] skip_t;
  typedef logic [DEF_PIX_BITS-1:0]  pix_t;

  // Encoding 3 is reserved and behaves as STOP.
  function automatic mode_e decode_mode(input logic [1:0] raw);
    case (raw)
      2'd1:    decode_mode = MODE_CONT;
      2'd2:    decode_mode = MODE_ONESHOT;
      default: decode_mode = MODE_STOP;
    endcase
  endfunction

endpackage

// File: rtl/img_buffer_frame_ctl_if.sv
// Incoming mat-stream beat qualifiers watched by the frame controller.
interface img_buffer_frame_ctl_if;
  logic valid;
  logic row_first;
  logic row_last;
  logic col_first;
  logic col_last;
  logic de;

  modport master (output valid, row_first, row_last, col_first, col_last, de);
  modport slave  (input  valid, row_first, row_last, col_first, col_last, de);
endinterface

// File: rtl/img_buffer_frame_sched.sv
// Per-frame capture decision: CONT skip counter and ONESHOT armed flag.
module img_buffer_frame_sched
  import img_buffer_pkg::*;
#(
  parameter int SKIP_BITS = 8
) (
  input  logic                 aclk,
  input  logic                 aresetn,
  input  logic                 cke,
  input  logic                 sof,
  input  logic [1:0]           cfg_mode,
  input  logic [SKIP_BITS-1:0] cfg_skip,
  input  logic                 cfg_trigger,
  output logic                 capture
);

  localparam logic [SKIP_BITS-1:0] SKIP_ONE = SKIP_BITS'(1);

  mode_e                mode;
  logic [SKIP_BITS-1:0] skip_cnt;
  logic                 armed;

  assign mode = decode_mode(cfg_mode);

  always_comb begin
    capture = 1'b0;
    if (sof) begin
      case (mode)
        MODE_CONT:    capture = (skip_cnt == '0);
        MODE_ONESHOT: capture = armed;
        default:      capture = 1'b0;
      endcase
    end
  end

  // A trigger coincident with SOF re-arms for the following frame; the
  // decision above has already used the pre-trigger armed value.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      skip_cnt <= '0;
      armed    <= 1'b0;
    end else if (cke) begin
      if (sof && mode == MODE_CONT)
        skip_cnt <= (skip_cnt == '0) ? cfg_skip : skip_cnt - SKIP_ONE;
      if (cfg_trigger)
        armed <= 1'b1;
      else if (sof && mode == MODE_ONESHOT)
        armed <= 1'b0;
    end
  end

endmodule

// File: rtl/img_buffer_frame_ctl.sv
// Frame-level write scheduler for the optical-flow image buffer.
// Optional watchdog: define IMG_BUFFER_FRAME_CTL_TIMEOUT_EN.
//
//   state    | meaning
//   ---------+-----------------------------------
//   ST_IDLE  | no frame in progress
//   ST_WRITE | capturing the current frame
//   ST_PASS  | frame in progress, not captured
module img_buffer_frame_ctl
  import img_buffer_pkg::*;
#(
  parameter int BUF_SIZE       = 640 * 480,
  parameter int SKIP_BITS      = 8,
  parameter int PIX_BITS       = $clog2(BUF_SIZE) + 1,
  parameter int FCNT_BITS      = 16,
  parameter int TIMEOUT_CYCLES = 1 << 24
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic                  cke,
  img_buffer_frame_ctl_if.slave s,
  input  logic [1:0]            cfg_mode,
  input  logic [SKIP_BITS-1:0]  cfg_skip,
  input  logic                  cfg_trigger,
  input  logic [PIX_BITS-1:0]   cfg_frame_pixels,
  output logic                  wr_gate,
  output logic                  ref_valid,
  output logic                  frame_start,
  output logic [FCNT_BITS-1:0]  frame_count,
  output logic                  st_busy,
  output logic                  st_overflow,
  output logic                  st_error
);

  localparam logic [PIX_BITS-1:0]  BUF_LIM  = PIX_BITS'(BUF_SIZE);
  localparam logic [FCNT_BITS-1:0] FCNT_ONE = FCNT_BITS'(1);

  state_e              state, state_nxt;
  logic                sof, eof, de_beat, capture;
  logic [PIX_BITS-1:0] pix_cnt, pix_inc, frm_pix;
  logic                pix_full, ovf;
  logic                ovf_hit, eof_ok, eof_bad, abandon, wd_fire;

  assign sof     = s.valid & s.row_first & s.col_first;
  assign eof     = s.valid & s.row_last & s.col_last;
  assign de_beat = s.valid & s.de;

  assign pix_full = (pix_cnt == BUF_LIM);
  assign pix_inc  = pix_cnt + PIX_BITS'(de_beat & ~pix_full);

  img_buffer_frame_sched #(
    .SKIP_BITS (SKIP_BITS)
  ) u_sched (
    .aclk        (aclk),
    .aresetn     (aresetn),
    .cke         (cke),
    .sof         (sof),
    .cfg_mode    (cfg_mode),
    .cfg_skip    (cfg_skip),
    .cfg_trigger (cfg_trigger),
    .capture     (capture)
  );

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn)
      state <= ST_IDLE;
    else if (cke)
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    ovf_hit   = 1'b0;
    eof_ok    = 1'b0;
    eof_bad   = 1'b0;
    abandon   = 1'b0;
    if (sof) begin
      abandon   = (state != ST_IDLE);
      state_nxt = capture ? ST_WRITE : ST_PASS;
    end else begin
      ovf_hit = (state == ST_WRITE) && de_beat && pix_full && !ovf;
      if (eof) begin
        case (state)
          ST_WRITE: begin
            state_nxt = ST_IDLE;
            // pix_inc includes the EOF beat itself
            if (!ovf && !ovf_hit && pix_inc == frm_pix)
              eof_ok = 1'b1;
            else
              eof_bad = 1'b1;
          end
          ST_PASS: state_nxt = ST_IDLE;
          default: state_nxt = state;
        endcase
      end
    end
    if (wd_fire)
      state_nxt = ST_IDLE;
  end

  // On the SOF beat the buffer must see the decision in the same cycle.
  assign wr_gate = sof ? capture : (state == ST_WRITE) && !pix_full;
  assign st_busy = (state == ST_WRITE);

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      pix_cnt     <= '0;
      frm_pix     <= '0;
      ovf         <= 1'b0;
      ref_valid   <= 1'b0;
      frame_count <= '0;
      st_overflow <= 1'b0;
      st_error    <= 1'b0;
    end else if (cke) begin
      if (sof) begin
        pix_cnt <= PIX_BITS'(s.de);
        frm_pix <= cfg_frame_pixels;
        ovf     <= 1'b0;
      end else if (state != ST_IDLE) begin
        pix_cnt <= pix_inc;
      end
      if (ovf_hit) begin
        ovf         <= 1'b1;
        st_overflow <= 1'b1;
      end
      if ((abandon && state == ST_WRITE) || ovf_hit || eof_bad || wd_fire)
        ref_valid <= 1'b0;
      else if (eof_ok)
        ref_valid <= 1'b1;
      if (eof_ok)
        frame_count <= frame_count + FCNT_ONE;
      if (abandon || eof_bad || wd_fire)
        st_error <= 1'b1;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn)
      frame_start <= 1'b0;
    else
      frame_start <= cke & sof;
  end

`ifdef IMG_BUFFER_FRAME_CTL_TIMEOUT_EN
  localparam int WD_BITS = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_BITS-1:0] WD_ONE  = WD_BITS'(1);
  localparam logic [WD_BITS-1:0] WD_LOAD = WD_BITS'(TIMEOUT_CYCLES);

  logic [WD_BITS-1:0] wd_cnt;

  // Down-counter reloaded on SOF; terminal count fires once, then it parks at 0.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn)
      wd_cnt <= '0;
    else if (cke) begin
      if (sof)
        wd_cnt <= WD_LOAD;
      else if (wd_cnt != '0)
        wd_cnt <= wd_cnt - WD_ONE;
    end
  end

  assign wd_fire = cke && !sof && (state != ST_IDLE) && (wd_cnt == WD_ONE);
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYCLES > 0);
  assign wd_fire        = 1'b0;
`endif

endmodule

// File: tb/tb_img_buffer_frame_ctl.sv
// Directed bench for img_buffer_frame_ctl, built with a 16-pixel buffer.
module tb_img_buffer_frame_ctl;

  localparam int BUF_SIZE  = 16;
  localparam int SKIP_BITS = 8;
  localparam int PIX_BITS  = $clog2(BUF_SIZE) + 1;
  localparam int FCNT_BITS = 16;

  logic                 aclk    = 1'b0;
  logic                 aresetn = 1'b0;
  logic                 cke     = 1'b0;
  logic [1:0]           cfg_mode = 2'd0;
  logic [SKIP_BITS-1:0] cfg_skip = '0;
  logic                 cfg_trigger = 1'b0;
  logic [PIX_BITS-1:0]  cfg_frame_pixels = PIX_BITS'(16);
  logic                 wr_gate, ref_valid, frame_start, st_busy, st_overflow, st_error;
  logic [FCNT_BITS-1:0] frame_count;

  int errors = 0;
  int checks = 0;

  img_buffer_frame_ctl_if s_if ();

  img_buffer_frame_ctl #(
    .BUF_SIZE  (BUF_SIZE),
    .SKIP_BITS (SKIP_BITS),
    .PIX_BITS  (PIX_BITS),
    .FCNT_BITS (FCNT_BITS)
  ) dut (
    .aclk             (aclk),
    .aresetn          (aresetn),
    .cke              (cke),
    .s                (s_if),
    .cfg_mode         (cfg_mode),
    .cfg_skip         (cfg_skip),
    .cfg_trigger      (cfg_trigger),
    .cfg_frame_pixels (cfg_frame_pixels),
    .wr_gate          (wr_gate),
    .ref_valid        (ref_valid),
    .frame_start      (frame_start),
    .frame_count      (frame_count),
    .st_busy          (st_busy),
    .st_overflow      (st_overflow),
    .st_error         (st_error)
  );

  always #5 aclk = ~aclk;

  task automatic clear_stream();
    s_if.valid     = 1'b0;
    s_if.row_first = 1'b0;
    s_if.row_last  = 1'b0;
    s_if.col_first = 1'b0;
    s_if.col_last  = 1'b0;
    s_if.de        = 1'b0;
  endtask

  task automatic do_reset();
    aresetn = 1'b0;
    cke = 1'b1;
    clear_stream();
    cfg_mode = 2'd0;
    cfg_skip = '0;
    cfg_trigger = 1'b0;
    cfg_frame_pixels = PIX_BITS'(16);
    repeat (2) @(negedge aclk);
    aresetn = 1'b1;
    @(negedge aclk);
  endtask

  // Drives up to stop_at beats of a rows x cols frame (all de=1), then one idle cycle.
  task automatic send_frame(input int rows, input int cols, input int stop_at,
                            input int stall_at, input bit trig_sof,
                            output int gates, output int first_off,
                            output bit fs, output bit rv1, output bit err1);
    int n;
    n = 0; gates = 0; first_off = -1; fs = 1'b0; rv1 = 1'b0; err1 = 1'b0;
    for (int r = 0; r < rows; r++) begin
      for (int c = 0; c < cols; c++) begin
        if (n < stop_at) begin
          @(negedge aclk);
          if (n == 1) begin
            fs = frame_start; rv1 = ref_valid; err1 = st_error;
          end
          s_if.valid     = 1'b1;
          s_if.row_first = (r == 0);
          s_if.row_last  = (r == rows - 1);
          s_if.col_first = (c == 0);
          s_if.col_last  = (c == cols - 1);
          s_if.de        = 1'b1;
          cfg_trigger    = trig_sof && (n == 0);
          if (n == stall_at) begin
            cke = 1'b0;
            repeat (10) @(negedge aclk);
            cke = 1'b1;
          end
          #1;
          if (wr_gate) gates++;
          else if (first_off < 0) first_off = n;
          n++;
        end
      end
    end
    @(negedge aclk);
    clear_stream();
    cfg_trigger = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    checks++; if (wr_gate !== 1'b0) begin errors++; $display("FAIL reset_wr_gate: got %b expected 0", wr_gate); end
    checks++; if (ref_valid !== 1'b0) begin errors++; $display("FAIL reset_ref_valid: got %b expected 0", ref_valid); end
    checks++; if (frame_start !== 1'b0) begin errors++; $display("FAIL reset_frame_start: got %b expected 0", frame_start); end
    checks++; if (frame_count !== 16'd0) begin errors++; $display("FAIL reset_frame_count: got %0d expected 0", frame_count); end
    checks++; if (st_busy !== 1'b0) begin errors++; $display("FAIL reset_st_busy: got %b expected 0", st_busy); end
    checks++; if (st_overflow !== 1'b0) begin errors++; $display("FAIL reset_st_overflow: got %b expected 0", st_overflow); end
    checks++; if (st_error !== 1'b0) begin errors++; $display("FAIL reset_st_error: got %b expected 0", st_error); end
  endtask

  task automatic test_cont();
    int exp_g[7] = '{16, 0, 0, 16, 0, 0, 16};
    int g, fo;
    bit fs, rv, er;
    do_reset();
    cfg_mode = 2'd1;
    cfg_skip = 8'd2;
    for (int i = 0; i < 7; i++) begin
      send_frame(4, 4, 16, -1, 1'b0, g, fo, fs, rv, er);
      checks++; if (g !== exp_g[i]) begin errors++; $display("FAIL cont_gates[%0d]: got %0d expected %0d", i, g, exp_g[i]); end
      checks++; if (fs !== 1'b1) begin errors++; $display("FAIL cont_frame_start[%0d]: got %b expected 1", i, fs); end
      if (i == 0) begin
        checks++; if (ref_valid !== 1'b1) begin errors++; $display("FAIL cont_ref_valid_f0: got %b expected 1", ref_valid); end
        checks++; if (frame_count !== 16'd1) begin errors++; $display("FAIL cont_count_f0: got %0d expected 1", frame_count); end
      end
    end
    checks++; if (frame_count !== 16'd3) begin errors++; $display("FAIL cont_count_end: got %0d expected 3", frame_count); end
    checks++; if (st_error !== 1'b0) begin errors++; $display("FAIL cont_st_error: got %b expected 0", st_error); end
  endtask

  task automatic test_oneshot();
    int exp_g[3] = '{16, 0, 0};
    int g, fo;
    bit fs, rv, er;
    do_reset();
    cfg_mode = 2'd2;
    @(negedge aclk); cfg_trigger = 1'b1;
    @(negedge aclk); cfg_trigger = 1'b0;
    for (int i = 0; i < 3; i++) begin
      send_frame(4, 4, 16, -1, 1'b0, g, fo, fs, rv, er);
      checks++; if (g !== exp_g[i]) begin errors++; $display("FAIL oneshot_gates[%0d]: got %0d expected %0d", i, g, exp_g[i]); end
    end
    checks++; if (frame_count !== 16'd1) begin errors++; $display("FAIL oneshot_count: got %0d expected 1", frame_count); end
    send_frame(4, 4, 16, -1, 1'b1, g, fo, fs, rv, er);
    checks++; if (g !== 0) begin errors++; $display("FAIL oneshot_trig_on_sof: got %0d expected 0", g); end
    send_frame(4, 4, 16, -1, 1'b0, g, fo, fs, rv, er);
    checks++; if (g !== 16) begin errors++; $display("FAIL oneshot_after_trig: got %0d expected 16", g); end
    checks++; if (frame_count !== 16'd2) begin errors++; $display("FAIL oneshot_count_end: got %0d expected 2", frame_count); end
  endtask

  task automatic test_overflow();
    int g, fo;
    bit fs, rv, er;
    do_reset();
    cfg_mode = 2'd1;
    send_frame(4, 4, 16, -1, 1'b0, g, fo, fs, rv, er);
    checks++; if (st_overflow !== 1'b0) begin errors++; $display("FAIL ovf_exact_fill: got %b expected 0", st_overflow); end
    checks++; if (ref_valid !== 1'b1) begin errors++; $display("FAIL ovf_pre_ref_valid: got %b expected 1", ref_valid); end
    cfg_frame_pixels = PIX_BITS'(20);
    send_frame(5, 4, 20, -1, 1'b0, g, fo, fs, rv, er);
    checks++; if (g !== 16) begin errors++; $display("FAIL ovf_gates: got %0d expected 16", g); end
    checks++; if (fo !== 16) begin errors++; $display("FAIL ovf_drop_beat: got %0d expected 16", fo); end
    checks++; if (st_overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %b expected 1", st_overflow); end
    checks++; if (ref_valid !== 1'b0) begin errors++; $display("FAIL ovf_ref_valid: got %b expected 0", ref_valid); end
    checks++; if (frame_count !== 16'd1) begin errors++; $display("FAIL ovf_count: got %0d expected 1", frame_count); end
    checks++; if (st_error !== 1'b1) begin errors++; $display("FAIL ovf_st_error: got %b expected 1", st_error); end
  endtask

  task automatic test_sof_abort();
    int g, fo;
    bit fs, rv, er;
    do_reset();
    cfg_mode = 2'd1;
    send_frame(4, 4, 16, -1, 1'b0, g, fo, fs, rv, er);
    send_frame(4, 4, 8, -1, 1'b0, g, fo, fs, rv, er);
    checks++; if (g !== 8) begin errors++; $display("FAIL abort_partial_gates: got %0d expected 8", g); end
    checks++; if (st_error !== 1'b0) begin errors++; $display("FAIL abort_pre_error: got %b expected 0", st_error); end
    send_frame(4, 4, 16, -1, 1'b0, g, fo, fs, rv, er);
    checks++; if (rv !== 1'b0) begin errors++; $display("FAIL abort_ref_valid: got %b expected 0", rv); end
    checks++; if (er !== 1'b1) begin errors++; $display("FAIL abort_st_error: got %b expected 1", er); end
    checks++; if (g !== 16) begin errors++; $display("FAIL abort_new_gates: got %0d expected 16", g); end
    checks++; if (ref_valid !== 1'b1) begin errors++; $display("FAIL abort_new_ref_valid: got %b expected 1", ref_valid); end
    checks++; if (frame_count !== 16'd2) begin errors++; $display("FAIL abort_count: got %0d expected 2", frame_count); end
  endtask

  task automatic test_async_reset();
    int g, fo;
    bit fs, rv, er;
    do_reset();
    cfg_mode = 2'd1;
    send_frame(4, 4, 16, -1, 1'b0, g, fo, fs, rv, er);
    send_frame(4, 4, 8, -1, 1'b0, g, fo, fs, rv, er);
    checks++; if (st_busy !== 1'b1) begin errors++; $display("FAIL areset_pre_busy: got %b expected 1", st_busy); end
    #2 aresetn = 1'b0;
    #1;
    checks++; if (st_busy !== 1'b0) begin errors++; $display("FAIL areset_busy: got %b expected 0", st_busy); end
    checks++; if (wr_gate !== 1'b0) begin errors++; $display("FAIL areset_wr_gate: got %b expected 0", wr_gate); end
    checks++; if (ref_valid !== 1'b0) begin errors++; $display("FAIL areset_ref_valid: got %b expected 0", ref_valid); end
    checks++; if (frame_count !== 16'd0) begin errors++; $display("FAIL areset_count: got %0d expected 0", frame_count); end
    @(negedge aclk);
    aresetn = 1'b1;
    @(negedge aclk);
    send_frame(4, 4, 16, -1, 1'b0, g, fo, fs, rv, er);
    checks++; if (g !== 16) begin errors++; $display("FAIL areset_next_gates: got %0d expected 16", g); end
    checks++; if (frame_count !== 16'd1) begin errors++; $display("FAIL areset_next_count: got %0d expected 1", frame_count); end
  endtask

  task automatic test_cke_stall();
    int g, fo;
    bit fs, rv, er;
    do_reset();
    cfg_mode = 2'd1;
    send_frame(4, 4, 16, 7, 1'b0, g, fo, fs, rv, er);
    checks++; if (g !== 16) begin errors++; $display("FAIL stall_gates: got %0d expected 16", g); end
    checks++; if (ref_valid !== 1'b1) begin errors++; $display("FAIL stall_ref_valid: got %b expected 1", ref_valid); end
    checks++; if (frame_count !== 16'd1) begin errors++; $display("FAIL stall_count: got %0d expected 1", frame_count); end
    checks++; if (st_overflow !== 1'b0) begin errors++; $display("FAIL stall_overflow: got %b expected 0", st_overflow); end
    checks++; if (st_error !== 1'b0) begin errors++; $display("FAIL stall_error: got %b expected 0", st_error); end
  endtask

  initial begin
    clear_stream();
    test_reset();
    test_cont();
    test_oneshot();
    test_overflow();
    test_sof_abort();
    test_async_reset();
    test_cke_stall();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/img_buffer_frame_ctl.md
Name: img_buffer_frame_ctl

Overview:
Frame-level write scheduler for the optical-flow image buffer. It watches the incoming mat stream and decides, per frame, whether the buffer captures that frame as the new reference or keeps the stored one. It also tracks whether the stored reference is complete, and reports overflow and sequencing errors. It sits beside the buffer on the same clock; its wr_gate output qualifies the buffer's per-pixel write enable.

Parameters:
BUF_SIZE, 640*480, buffer capacity in pixels (beats with de).
SKIP_BITS, 8, width of the frame-skip counter.
PIX_BITS, $clog2(BUF_SIZE)+1, width of the per-frame pixel counter.
FCNT_BITS, 16, width of the captured-frame counter.
TIMEOUT_CYCLES, 1<<24, watchdog limit; used only with the optional feature.

Ports:
aclk  in  1  clock
aresetn  in  1  asynchronous active-low reset
cke  in  1  pipeline clock enable, shared with the buffer
s_valid  in  1  stream beat valid
s_row_first  in  1  first row
s_row_last  in  1  last row
s_col_first  in  1  first column
s_col_last  in  1  last column
s_de  in  1  pixel data enable
cfg_mode  in  2  0=STOP, 1=CONT, 2=ONESHOT, 3=STOP
cfg_skip  in  SKIP_BITS  frames skipped between captures in CONT mode
cfg_trigger  in  1  one-cycle arm pulse for ONESHOT
cfg_frame_pixels  in  PIX_BITS  expected pixels per frame
wr_gate  out  1  buffer write qualifier for the current beat
ref_valid  out  1  stored reference is a complete, good frame
frame_start  out  1  one-cycle pulse on every SOF beat
frame_count  out  FCNT_BITS  captured frames, wraps
st_busy  out  1  currently capturing
st_overflow  out  1  sticky: a frame exceeded BUF_SIZE
st_error  out  1  sticky: size mismatch or SOF before EOF

Behaviour:
- Definitions: SOF = s_valid & s_row_first & s_col_first. EOF = s_valid & s_row_last & s_col_last. All state advances only when cke=1.
- Reset values: state=IDLE, wr_gate=0, ref_valid=0, frame_start=0, frame_count=0, st_*=0, skip counter=0, oneshot armed=0.
- States:
  - IDLE: no frame in progress.
  - WRITE: capturing the current frame.
  - PASS: frame in progress, not captured.
- Config is sampled only on the SOF beat. Mid-frame config changes take effect at the next SOF.
- Capture decision at SOF:
  - CONT: capture if skip_cnt==0, then reload skip_cnt=cfg_skip. Otherwise decrement skip_cnt.
  - ONESHOT: capture if armed, then clear armed.
  - STOP: never capture.
- cfg_trigger sets armed in any state. A trigger and an SOF in the same cycle uses the pre-trigger armed value.
- wr_gate:
  - On the SOF beat it equals the capture decision (combinational on SOF).
  - Afterwards it is registered: 1 while in WRITE and pixel count < BUF_SIZE, else 0.
- Pixel counter: reset to 1 on SOF when that beat has de=1 (0 otherwise). Increments on valid & de. Saturates at BUF_SIZE.
- Overflow: the first de beat with count==BUF_SIZE clears wr_gate for the rest of the frame, sets st_overflow, clears ref_valid, and the frame is not counted.
- EOF in WRITE:
  - count==cfg_frame_pixels and no overflow → ref_valid=1, frame_count+1.
  - Otherwise → ref_valid=0, st_error=1.
  - State returns to IDLE.
- EOF in PASS → IDLE, no flag changes.
- ref_valid is not cleared at the start of a new capture; the buffer reads before it writes per address.
- SOF while in WRITE or PASS: the old frame is abandoned (ref_valid=0 if it was WRITE), st_error=1, and the new frame is handled as a normal SOF.
- frame_start is registered, one cycle after the SOF beat.
- st_busy = (state==WRITE).
- Sticky flags clear only on reset.

Optional Feature:
IMG_BUFFER_FRAME_CTL_TIMEOUT_EN
- Defined: a watchdog counts cke cycles since the last SOF. At TIMEOUT_CYCLES it forces state=IDLE, wr_gate=0, ref_valid=0 and sets st_error. The counter holds until the next SOF.
- Undefined: no watchdog logic; state waits indefinitely.

Decomposition:
- Package img_buffer_pkg holds:
  - the mode enum (MODE_STOP, MODE_CONT, MODE_ONESHOT);
  - the state enum (ST_IDLE, ST_WRITE, ST_PASS);
  - pix_t / skip_t typedef helpers.
- One sub-module: img_buffer_frame_sched, holding the combinational capture decision plus the skip counter and armed flag.
- The FSM, counters and status logic stay in the top module.

Test Plan:
- CONT, cfg_skip=2, 7 frames of 4x4, cfg_frame_pixels=16 → wr_gate high in frames 0, 3, 6. frame_count=3, ref_valid=1 after frame 0 EOF.
- ONESHOT: trigger, 3 frames → only frame 0 captured. Trigger in the same cycle as frame 1 SOF → frame 1 not captured, frame 2 captured.
- BUF_SIZE=16, 5x4 frame → wr_gate drops at the 17th de beat. st_overflow=1, ref_valid=0, frame_count unchanged.
- SOF injected at beat 8 of a WRITE frame → st_error=1, ref_valid=0, new frame captured normally.
- aresetn low mid-WRITE (asynchronous, between edges) → all outputs 0 immediately. The next frame in CONT mode, cfg_skip=0, is captured.
- cke=0 for 10 cycles mid-frame → no counter or state change; capture completes with count=16.
